// File: rtl/frame_scan_sched_pkg.sv
// Shared types and defaults for the frame raster-scan scheduler.
package frame_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } scan_state_e;

  localparam int ROW_W_DEF   = 8;
  localparam int COL_W_DEF   = 8;
  localparam int LATENCY_DEF = 8;
  localparam int MAX_LATENCY = 32;

endpackage

// File: rtl/frame_scan_sched_if.sv
// Control/status and memory-address bundle of the scan scheduler.
// SCAN_STALL_CNT_EN adds the stall_cycles statistic.
interface frame_scan_sched_if
  import frame_scan_pkg::*;
#(
  parameter int ROW_W = ROW_W_DEF,
  parameter int COL_W = COL_W_DEF
);
  logic             start;
  logic             abort;
  logic             stall;
  logic [ROW_W-1:0] last_row;
  logic [COL_W-1:0] last_col;
  logic             busy;
  logic             done;
  logic             act;
  logic             rd;
  logic             wr;
  logic [ROW_W-1:0] addr_row_r;
  logic [COL_W-1:0] addr_col_r;
  logic [ROW_W-1:0] addr_row_w;
  logic [COL_W-1:0] addr_col_w;
`ifdef SCAN_STALL_CNT_EN
  logic [31:0]      stall_cycles;
`endif

  // Controller side
  modport master (
    output start, abort, stall, last_row, last_col,
    input  busy, done, act, rd, wr,
    input  addr_row_r, addr_col_r, addr_row_w, addr_col_w
`ifdef SCAN_STALL_CNT_EN
    , input stall_cycles
`endif
  );

  // Scheduler side
  modport slave (
    input  start, abort, stall, last_row, last_col,
    output busy, done, act, rd, wr,
    output addr_row_r, addr_col_r, addr_row_w, addr_col_w
`ifdef SCAN_STALL_CNT_EN
    , output stall_cycles
`endif
  );

endinterface

// File: rtl/frame_scan_sched_addr_gen.sv
// Raster row/col counter: column-first, col wraps last_col->0 and bumps row.
// The counter parks on (last_row,last_col) and ignores further advances.
module scan_addr_gen
  import frame_scan_pkg::*;
#(
  parameter int ROW_W = ROW_W_DEF,
  parameter int COL_W = COL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  input  logic [ROW_W-1:0] last_row,
  input  logic [COL_W-1:0] last_col,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             is_last
);

  assign is_last = (row == last_row) && (col == last_col);

  // Address counter with synchronous clear and wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (adv && !is_last) begin
      if (col == last_col) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_scan_sched.sv
// Frame raster-scan scheduler: issues reads in raster order, tracks them
// through a LATENCY-deep valid pipeline and issues the matching writes.
// Optional: SCAN_STALL_CNT_EN adds a saturating stall-cycle counter.
module frame_scan_sched
  import frame_scan_pkg::*;
#(
  parameter int ROW_W   = ROW_W_DEF,
  parameter int COL_W   = COL_W_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  frame_scan_sched_if.slave    bus
);

  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("frame_scan_sched: LATENCY out of range 1..%0d", MAX_LATENCY);
  end

  scan_state_e      state, state_nxt;
  logic [ROW_W-1:0] lr_q;
  logic [COL_W-1:0] lc_q;
  logic [LATENCY-1:0] vld_pipe, pipe_nxt;
  logic             start_ok, abort_ok;
  logic             rd_i, wr_i, act_i, busy_i, done_i;
  logic             rd_last, wr_last;

  assign start_ok = bus.start && (state == IDLE);
  assign abort_ok = bus.abort && (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: abort wins over everything outside IDLE
  always_comb begin
    state_nxt = state;
    if (abort_ok) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start)        state_nxt = RUN;
        RUN:     if (rd_i && rd_last)  state_nxt = DRAIN;
        DRAIN:   if (wr_i && wr_last)  state_nxt = FIN;
        FIN:                           state_nxt = IDLE;
        default:                       state_nxt = IDLE;
      endcase
    end
  end

  // Outputs decoded from state; stall gates both strobes
  always_comb begin
    rd_i   = 1'b0;
    act_i  = 1'b0;
    busy_i = 1'b0;
    done_i = 1'b0;
    case (state)
      RUN:   begin rd_i = ~bus.stall; act_i = 1'b1; busy_i = 1'b1; end
      DRAIN: begin act_i = 1'b1; busy_i = 1'b1; end
      FIN:   done_i = 1'b1;
      default: ;
    endcase
    wr_i = vld_pipe[LATENCY-1] & ~bus.stall;
  end

  // Frame size is captured once per scan so the inputs may change mid-scan
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lr_q <= '0;
      lc_q <= '0;
    end else if (start_ok) begin
      lr_q <= bus.last_row;
      lc_q <= bus.last_col;
    end
  end

  if (LATENCY == 1) begin : g_pipe1
    assign pipe_nxt = rd_i;
  end else begin : g_pipen
    assign pipe_nxt = {vld_pipe[LATENCY-2:0], rd_i};
  end

  // Valid pipeline: frozen by stall, flushed by abort
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             vld_pipe <= '0;
    else if (abort_ok)    vld_pipe <= '0;
    else if (!bus.stall)  vld_pipe <= pipe_nxt;
  end

  scan_addr_gen #(.ROW_W(ROW_W), .COL_W(COL_W)) u_rd_addr (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_ok),
    .adv      (rd_i && !abort_ok),
    .last_row (lr_q),
    .last_col (lc_q),
    .row      (bus.addr_row_r),
    .col      (bus.addr_col_r),
    .is_last  (rd_last)
  );

  scan_addr_gen #(.ROW_W(ROW_W), .COL_W(COL_W)) u_wr_addr (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_ok),
    .adv      (wr_i && !abort_ok),
    .last_row (lr_q),
    .last_col (lc_q),
    .row      (bus.addr_row_w),
    .col      (bus.addr_col_w),
    .is_last  (wr_last)
  );

  assign bus.rd   = rd_i;
  assign bus.wr   = wr_i;
  assign bus.act  = act_i;
  assign bus.busy = busy_i;
  assign bus.done = done_i;

`ifdef SCAN_STALL_CNT_EN
  logic [31:0] stall_cnt;

  // Busy cycles spent stalled, saturating; held once the scan ends
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                       stall_cnt <= '0;
    else if (start_ok)                              stall_cnt <= '0;
    else if (busy_i && bus.stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
  end

  assign bus.stall_cycles = stall_cnt;
`endif

endmodule

// File: doc/frame_scan_sched.md
Name: frame_scan_sched

Overview:
- Sequences one raster scan of the 2-D frame memory through the pixel pipeline.
- Issues read addresses and rd strobes to the source memory. Writes results back to the destination memory after a fixed pipeline latency.
- Adds a start/busy/done handshake, a downstream stall, abort, and run-time frame size, replacing free-running count-based sequencing.
- Sits between the top-level control FSM and the frame memories/pipeline.

Parameters:
- ROW_W, 8, row address width.
- COL_W, 8, column address width.
- LATENCY, 8, pipeline depth in cycles from rd to matching wr; legal range 1..32.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a scan when idle.
- abort  in  1  terminates the scan; no done is produced.
- stall  in  1  downstream backpressure; freezes the issue counters and the pipeline.
- last_row  in  ROW_W  index of the final row; sampled on an accepted start.
- last_col  in  COL_W  index of the final column; sampled on an accepted start.
- busy  out  1  high from an accepted start until done or abort.
- done  out  1  one-cycle pulse after the final write.
- act  out  1  pipeline active enable.
- rd  out  1  read strobe to the source memory.
- wr  out  1  write strobe to the destination memory.
- addr_row_r  out  ROW_W  read row address.
- addr_col_r  out  COL_W  read column address.
- addr_row_w  out  ROW_W  write row address.
- addr_col_w  out  COL_W  write column address.

Behaviour:
- Reset (async, rst=0): all outputs 0, state IDLE, pipeline valid bits 0, latched sizes 0.
- States: IDLE, RUN, DRAIN, FIN.
- IDLE: a start pulse latches last_row/last_col, sets busy, clears both address pairs to 0, and enters RUN next cycle. Start in any other state is ignored.
- RUN:
  - act=1.
  - rd = ~stall.
  - The read address advances only on cycles where rd=1: column-first, col wraps last_col->0 and row increments.
  - The read issued at (last_row,last_col) moves the FSM to DRAIN; the address holds there.
- Valid pipeline: LATENCY-bit shift register, input = rd.
  - Shifts only when stall=0; stall=1 freezes all bits.
  - wr = pipeline output bit & ~stall.
- Write address: advances on each wr with the same wrap rule as the read address. The first wr targets (0,0).
- DRAIN: rd=0, act=1. The wr at (last_row,last_col) moves the FSM to FIN.
- FIN: done=1 and busy=0 for one cycle, act=0, then IDLE. The address outputs hold their final values.
- Each scan produces exactly (last_row+1)*(last_col+1) rd pulses and the same number of wr pulses. The k-th wr carries the address of the k-th rd.
- With no stall, the k-th wr occurs exactly LATENCY cycles after the k-th rd.
- Size 1x1 (last_row=last_col=0): one rd, then one wr LATENCY cycles later, then done.
- abort (any non-IDLE state, highest priority over stall and start):
  - Next cycle: IDLE, pipeline cleared, rd=wr=act=busy=0, no done.
  - Addresses hold their values.
- Reset mid-scan: immediate return to reset values; no partial done.

Optional Feature:
- Macro: SCAN_STALL_CNT_EN.
- When defined, adds port stall_cycles (out, 32): cleared on an accepted start, increments every busy cycle with stall=1, saturates at 0xFFFFFFFF, holds after done or abort, reset to 0.
- When undefined, the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package frame_scan_pkg: state encoding (IDLE, RUN, DRAIN, FIN), default widths, and MAX_LATENCY=32 for parameter checking.
- Sub-module scan_addr_gen: row/col counter with clear, advance, and the last_row/last_col inputs; outputs row, col and an is_last flag.
- scan_addr_gen is instantiated twice, once for the read side and once for the write side.

Test Plan:
- Full frame, LATENCY=8, last_row=last_col=255, no stall:
  - rd at cycles 1..65536 after start.
  - First wr at cycle 9 with address (0,0); last wr at cycle 65544 with address (255,255).
  - done at cycle 65545; exactly 65536 wr pulses.
- 4x4 frame (last_row=last_col=3), LATENCY=2:
  - Read address sequence (0,0),(0,1)..(0,3),(1,0)..(3,3).
  - The write address sequence matches the read sequence, delayed 2 cycles.
  - Column wrap 3->0 increments the row.
- Stall during a 4x4 scan, stall=1 for 3 cycles around the 5th rd:
  - rd, wr, addresses and pipeline frozen during the stall.
  - Totals stay 16 rd and 16 wr; done is delayed by exactly 3 cycles.
  - With SCAN_STALL_CNT_EN, stall_cycles=3.
- 1x1 frame, LATENCY=1: rd at cycle 1, wr at (0,0) on cycle 2, done on cycle 3.
- Abort in DRAIN:
  - Next cycle busy=act=wr=0 and no done.
  - A new start then scans correctly from (0,0).
  - A start pulse issued while busy is ignored.
- Reset mid-RUN: all outputs 0 asynchronously, with no wr or done after rst is released.
